// File: rtl/fc_out_argmax_if.sv
// Bus bundle for the classifier output stage: MAC beat input, bias
// register write port, registered class scores and the argmax result.
interface fc_out_argmax_if #(
    parameter int NUM_CLASS = 10,
    parameter int DIN_W     = 23,
    parameter int BIAS_W    = 16,
    parameter int DOUT_W    = 16
);
    localparam int IDX_W = $clog2(NUM_CLASS);

    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_CLASS*DIN_W-1:0]  mac_in;
    logic                        bias_wr_en;
    logic [IDX_W-1:0]            bias_addr;
    logic [BIAS_W-1:0]           bias_data;
    logic [NUM_CLASS*DOUT_W-1:0] class_out;
    logic                        out_valid;
    logic [IDX_W-1:0]            class_idx;
    logic [DOUT_W-1:0]           max_val;
    logic                        idx_valid;

    modport master (
        output in_valid, mac_in, bias_wr_en, bias_addr, bias_data,
        input  in_ready, class_out, out_valid, class_idx, max_val, idx_valid
    );

    modport slave (
        input  in_valid, mac_in, bias_wr_en, bias_addr, bias_data,
        output in_ready, class_out, out_valid, class_idx, max_val, idx_valid
    );
endinterface

// File: rtl/fc_out_argmax.sv
// Classifier output stage: adds per-class bias to a beat of MAC results,
// scales and saturates into registered class scores, then scans them
// sequentially to report the winning class index and score.
module fc_out_argmax #(
    parameter int NUM_CLASS = 10,
    parameter int DIN_W     = 23,
    parameter int BIAS_W    = 16,
    parameter int DOUT_W    = 16,
    parameter int SHIFT     = 0
) (
    input  logic            clk,
    input  logic            rst_n,   // active-high synchronous reset
    fc_out_argmax_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_CLASS);
    localparam int SW    = DIN_W + 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]     LAST    = IDX_W'(NUM_CLASS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                      state_q, state_d;
    logic signed [BIAS_W-1:0]    bias_q [NUM_CLASS];
    logic signed [BIAS_W-1:0]    bias_d [NUM_CLASS];
    logic [NUM_CLASS*DOUT_W-1:0] class_q, class_d;
    logic                        out_valid_q, out_valid_d;
    logic                        idx_valid_q, idx_valid_d;
    logic [IDX_W-1:0]            class_idx_q, class_idx_d;
    logic [DOUT_W-1:0]           max_val_q, max_val_d;
    logic [IDX_W-1:0]            ptr_q, ptr_d;
    logic signed [DOUT_W-1:0]    run_max_q, run_max_d;
    logic [IDX_W-1:0]            run_idx_q, run_idx_d;

    logic [NUM_CLASS*DOUT_W-1:0] score_all;
    logic signed [SW-1:0]        sum;
    logic signed [SW-1:0]        shifted;
    logic signed [DOUT_W-1:0]    cur;
    logic signed [DOUT_W-1:0]    win_max;
    logic [IDX_W-1:0]            win_idx;
    logic                        accept;

    assign bus.in_ready  = (state_q != SCAN);
    assign bus.class_out = class_q;
    assign bus.out_valid = out_valid_q;
    assign bus.class_idx = class_idx_q;
    assign bus.max_val   = max_val_q;
    assign bus.idx_valid = idx_valid_q;
    assign accept        = bus.in_valid & bus.in_ready;

    // Bias register file update; capture below reads bias_q, so a same-edge write is not seen
    always_comb begin
        bias_d = bias_q;
        if (bus.bias_wr_en && (32'(bus.bias_addr) < NUM_CLASS)) begin
            bias_d[bus.bias_addr] = bus.bias_data;
        end
    end

    // Per-class bias add, arithmetic shift and saturation to DOUT_W
    always_comb begin
        score_all = '0;
        sum       = '0;
        shifted   = '0;
        for (int unsigned k = 0; k < NUM_CLASS; k++) begin
            sum = {bus.mac_in[k*DIN_W + DIN_W - 1], bus.mac_in[k*DIN_W +: DIN_W]}
                + {{(SW-BIAS_W){bias_q[k][BIAS_W-1]}}, bias_q[k]};
            shifted = sum >>> SHIFT;
            if (shifted > SAT_MAX) begin
                score_all[k*DOUT_W +: DOUT_W] = SAT_MAX[DOUT_W-1:0];
            end else if (shifted < SAT_MIN) begin
                score_all[k*DOUT_W +: DOUT_W] = SAT_MIN[DOUT_W-1:0];
            end else begin
                score_all[k*DOUT_W +: DOUT_W] = shifted[DOUT_W-1:0];
            end
        end
    end

    // FSM next state: capture on accept, then one class compared per cycle
    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        out_valid_d = 1'b0;
        idx_valid_d = 1'b0;
        class_idx_d = class_idx_q;
        max_val_d   = max_val_q;
        ptr_d       = ptr_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        cur         = $signed(class_q[ptr_q*DOUT_W +: DOUT_W]);
        win_max     = run_max_q;
        win_idx     = run_idx_q;

        // strictly-greater update keeps the lower index on ties
        if (cur > run_max_q) begin
            win_max = cur;
            win_idx = ptr_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    class_d     = score_all;
                    out_valid_d = 1'b1;
                    run_max_d   = $signed(score_all[DOUT_W-1:0]);
                    run_idx_d   = '0;
                    ptr_d       = IDX_W'(1);
                    state_d     = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                run_max_d = win_max;
                run_idx_d = win_idx;
                if (ptr_q == LAST) begin
                    class_idx_d = win_idx;
                    max_val_d   = win_max;
                    idx_valid_d = 1'b1;
                    ptr_d       = '0;
                    state_d     = DONE;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            for (int unsigned k = 0; k < NUM_CLASS; k++) begin
                bias_q[k] <= '0;
            end
            class_q     <= '0;
            out_valid_q <= 1'b0;
            idx_valid_q <= 1'b0;
            class_idx_q <= '0;
            max_val_q   <= '0;
            ptr_q       <= '0;
            run_max_q   <= '0;
            run_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            bias_q      <= bias_d;
            class_q     <= class_d;
            out_valid_q <= out_valid_d;
            idx_valid_q <= idx_valid_d;
            class_idx_q <= class_idx_d;
            max_val_q   <= max_val_d;
            ptr_q       <= ptr_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
        end
    end
endmodule
